// File: rtl/vga_portb_arbiter_pkg.sv
// Shared types and defaults for the RAM port-B arbiter between VGA scan-out and the host link.
package portb_arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 32'd12;
    localparam int unsigned DATA_W_DEF   = 32'd16;
    localparam int unsigned MAX_WAIT_DEF = 32'd4;
    localparam logic [11:0] PROT_TOP_DEF = 12'h100;

    // Grant tag; the host grants are split so a read can be told apart one cycle later.
    typedef enum logic [1:0] {
        GNT_NONE    = 2'd0,
        GNT_VGA     = 2'd1,
        GNT_HOST_RD = 2'd2,
        GNT_HOST_WR = 2'd3
    } gnt_e;

    function automatic logic is_host_gnt(input gnt_e gnt);
        return (gnt == GNT_HOST_RD) || (gnt == GNT_HOST_WR);
    endfunction

endpackage

// File: rtl/vga_portb_arbiter_wait_counter.sv
// Saturating count of consecutive cycles the host has been refused port B.
module arb_wait_counter #(
    parameter int unsigned MAX   = 32'd4,
    parameter int unsigned CNT_W = 32'd4
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             inc,
    input  logic             clr,
    output logic             sat,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment, increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == MAX_C);
    assign cnt = cnt_q;

endmodule

// File: rtl/vga_portb_arbiter.sv
// Port-B arbiter: VGA reads have fixed priority, the host is forced through after MAX_WAIT
// refused cycles, and host writes below PROT_TOP are acknowledged but never reach the RAM.
module vga_portb_arbiter
    import portb_arb_pkg::*;
#(
    parameter int unsigned        ADDR_W   = ADDR_W_DEF,
    parameter int unsigned        DATA_W   = DATA_W_DEF,
    parameter int unsigned        MAX_WAIT = MAX_WAIT_DEF,
    parameter logic [ADDR_W-1:0]  PROT_TOP = ADDR_W'(PROT_TOP_DEF)
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic              vga_miss,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic              host_rvalid,
    output logic              host_err,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    gnt_e              gnt_s;
    logic              force_host_s;
    logic              host_gnt_s;
    logic              prot_hit_s;
    logic              wait_sat_s;
    logic [3:0]        wait_cnt_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic              ram_we_s;

    gnt_e              last_gnt_q, last_gnt_d;
    logic              miss_q, miss_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    arb_wait_counter #(
        .MAX   (MAX_WAIT),
        .CNT_W (32'd4)
    ) u_wait (
        .clock (clock),
        .Reset (Reset),
        .inc   (host_req && !host_gnt_s),
        .clr   (host_gnt_s),
        .sat   (wait_sat_s),
        .cnt   (wait_cnt_s)
    );

    assign force_host_s = host_req && wait_sat_s;
    assign prot_hit_s   = (host_addr < PROT_TOP);
    assign host_gnt_s   = is_host_gnt(gnt_s);

    // Grant decision; held at NONE while Reset is low so nothing reaches the RAM.
    always_comb begin
        gnt_s = GNT_NONE;
        if (!Reset) begin
            gnt_s = GNT_NONE;
        end else if (force_host_s || (host_req && !vga_req)) begin
            gnt_s = host_we ? GNT_HOST_WR : GNT_HOST_RD;
        end else if (vga_req) begin
            gnt_s = GNT_VGA;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Port-B drive; an idle cycle keeps presenting the last granted address.
    always_comb begin
        ram_addr_s  = addr_q;
        ram_wdata_s = '0;
        ram_we_s    = 1'b0;
        case (gnt_s)
            GNT_VGA: begin
                ram_addr_s = vga_addr;
            end
            GNT_HOST_RD: begin
                ram_addr_s  = host_addr;
                ram_wdata_s = host_wdata;
            end
            GNT_HOST_WR: begin
                ram_addr_s  = host_addr;
                ram_wdata_s = host_wdata;
                ram_we_s    = !prot_hit_s;
            end
            GNT_NONE: begin
                ram_addr_s = addr_q;
            end
            default: begin
                ram_addr_s = addr_q;
            end
        endcase
    end

    // Next state of the per-cycle tag and the one-cycle-late status flags.
    always_comb begin
        last_gnt_d = gnt_s;
        miss_d     = vga_req && force_host_s;
        err_d      = (gnt_s == GNT_HOST_WR) && prot_hit_s;
        addr_d     = (gnt_s == GNT_NONE) ? addr_q : ram_addr_s;
    end

    // Tag and status registers; async clear cancels any pending valid/err.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            last_gnt_q <= GNT_NONE;
            miss_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
        end
    end

    assign ram_addr    = ram_addr_s;
    assign ram_wdata   = ram_wdata_s;
    assign ram_we      = ram_we_s;
    assign host_ack    = host_gnt_s;
    assign vga_valid   = (last_gnt_q == GNT_VGA);
    assign host_rvalid = (last_gnt_q == GNT_HOST_RD);
    assign vga_miss    = miss_q;
    assign host_err    = err_q;
    assign vga_rdata   = ram_q;
    assign host_rdata  = ram_q;

endmodule

// File: tb/tb_vga_portb_arbiter.sv
// Randomized bench for vga_portb_arbiter with a behavioural arbiter/RAM model and directed checks.
module tb_vga_portb_arbiter;

    localparam int          MW = 4;
    localparam logic [11:0] PT = 12'h100;

    logic        clock = 1'b0;
    logic        Reset = 1'b0;
    logic        vga_req = 1'b0;
    logic [11:0] vga_addr = 12'h000;
    logic        vga_valid, vga_miss;
    logic [15:0] vga_rdata;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [11:0] host_addr = 12'h000;
    logic [15:0] host_wdata = 16'h0000;
    logic        host_ack, host_rvalid, host_err;
    logic [15:0] host_rdata;
    logic [11:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_q;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    vga_portb_arbiter #(
        .ADDR_W(12), .DATA_W(16), .MAX_WAIT(MW), .PROT_TOP(PT)
    ) dut (
        .clock(clock), .Reset(Reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid),
        .vga_miss(vga_miss), .vga_rdata(vga_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rvalid(host_rvalid),
        .host_err(host_err), .host_rdata(host_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q)
    );

    function automatic logic [15:0] init_val(input logic [11:0] a);
        logic [31:0] t;
        if (a == 12'h200) return 16'hBEEF;
        if (a == 12'h0FF) return 16'h5A5A;
        t = ({20'd0, a} * 32'd40503) ^ 32'h1357;
        return t[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural RAM for port B: read-first, one cycle latency.
    logic [15:0] mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_val(12'(i));
        forever begin
            @(posedge clock);
            ram_q <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_wdata;
        end
    end

    // Reference model: grant rules applied with plain integers and a shadow memory.
    logic [15:0] shadow [0:4095];
    int          m_wait, m_last, e_g;
    bit          m_miss, m_err, e_force, e_ack, e_we;
    logic [15:0] m_q;
    logic [11:0] m_held, e_addr;
    initial begin
        for (int i = 0; i < 4096; i++) shadow[i] = init_val(12'(i));
        m_wait = 0; m_last = 0; m_miss = 0; m_err = 0; m_held = 12'h000; m_q = 16'h0000;
        forever begin
            @(negedge clock);
            #2;
            if (!Reset) begin
                chk("rst_ack", host_ack, 0);
                chk("rst_we", ram_we, 0);
                chk("rst_addr", ram_addr, 0);
                chk("rst_vvalid", vga_valid, 0);
                chk("rst_hrvalid", host_rvalid, 0);
                chk("rst_miss", vga_miss, 0);
                chk("rst_err", host_err, 0);
                m_wait = 0; m_last = 0; m_miss = 0; m_err = 0; m_held = 12'h000;
            end else begin
                e_force = host_req && (m_wait == MW);
                if (e_force || (host_req && !vga_req)) e_g = host_we ? 3 : 2;
                else if (vga_req) e_g = 1;
                else e_g = 0;
                e_ack  = (e_g >= 2);
                e_we   = (e_g == 3) && (host_addr >= PT);
                e_addr = e_ack ? host_addr : ((e_g == 1) ? vga_addr : m_held);
                chk("ack", host_ack, e_ack);
                chk("ram_we", ram_we, e_we);
                chk("ram_addr", ram_addr, e_addr);
                chk("vga_valid", vga_valid, m_last == 1);
                chk("host_rvalid", host_rvalid, m_last == 2);
                chk("vga_miss", vga_miss, m_miss);
                chk("host_err", host_err, m_err);
                if (m_last == 1) chk("vga_rdata", vga_rdata, m_q);
                if (m_last == 2) chk("host_rdata", host_rdata, m_q);
                if (e_we) chk("ram_wdata", ram_wdata, host_wdata);
                m_q = shadow[e_addr];
                if (e_we) shadow[host_addr] = host_wdata;
                m_last = e_g;
                m_miss = vga_req && e_force;
                m_err  = (e_g == 3) && (host_addr < PT);
                if (e_ack) m_wait = 0;
                else if (host_req && m_wait < MW) m_wait++;
                if (e_g != 0) m_held = e_addr;
            end
        end
    end

    task automatic drive(input bit r, input bit vr, input logic [11:0] va, input bit hr,
                         input bit we, input logic [11:0] ha, input logic [15:0] wd);
        @(negedge clock);
        Reset = r; vga_req = vr; vga_addr = va;
        host_req = hr; host_we = we; host_addr = ha; host_wdata = wd;
        #3;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000);
    endtask

    bit          hr_act, hr_we;
    logic [11:0] hr_addr;
    logic [15:0] hr_wd;

    initial begin
        // Reset held with both requesters active.
        repeat (3) drive(1'b0, 1'b1, 12'h200, 1'b1, 1'b0, 12'h300, 16'h0000);
        chk("L_rst_ack", host_ack, 0);
        chk("L_rst_vvalid", vga_valid, 0);
        chk("L_rst_addr", ram_addr, 0);
        drive(1'b1, 1'b1, 12'h200, 1'b1, 1'b0, 12'h300, 16'h0000);
        chk("L_rel_vga_first", ram_addr, 12'h200);
        chk("L_rel_no_ack", host_ack, 0);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h300, 16'h0000);
        chk("L_rel_vvalid", vga_valid, 1);
        chk("L_rel_vdata", vga_rdata, 16'hBEEF);
        chk("L_rel_host_ack", host_ack, 1);
        idle();

        // Uncontended host read.
        drive(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h200, 16'h0000);
        chk("L_rd_ack", host_ack, 1);
        idle();
        chk("L_rd_rvalid", host_rvalid, 1);
        chk("L_rd_data", host_rdata, 16'hBEEF);

        // Starvation bound under continuous VGA load.
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, 1'b1, 12'(12'h010 + c), c <= 4, 1'b0, 12'h300, 16'h0000);
            chk("L_starve_ack", host_ack, c == 4);
            if (c == 5) begin
                chk("L_starve_miss", vga_miss, 1);
                chk("L_starve_novalid", vga_valid, 0);
            end
            if (c == 6) chk("L_starve_resume", vga_valid, 1);
        end
        idle();

        // Write protection.
        drive(1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h0FF, 16'h1234);
        chk("L_prot_ack", host_ack, 1);
        chk("L_prot_we", ram_we, 0);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h0FF, 16'h0000);
        chk("L_prot_err", host_err, 1);
        idle();
        chk("L_prot_keep", host_rdata, 16'h5A5A);
        chk("L_prot_err_gone", host_err, 0);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h100, 16'hCAFE);
        chk("L_wr_we", ram_we, 1);
        chk("L_wr_addr", ram_addr, 12'h100);
        drive(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h100, 16'h0000);
        chk("L_wr_noerr", host_err, 0);
        idle();
        chk("L_wr_back", host_rdata, 16'hCAFE);

        // Abort keeps the wait count.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b1, 12'h020, c != 2, 1'b0, 12'h200, 16'h0000);
            chk("L_abort_ack", host_ack, c == 5);
        end
        idle();

        // Reset in the cycle after a host read grant.
        drive(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h200, 16'h0000);
        chk("L_mid_ack", host_ack, 1);
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000);
        chk("L_mid_cancel", host_rvalid, 0);
        drive(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            idle();
            chk("L_mid_after", host_rvalid, 0);
        end

        // Randomized traffic with a host that holds its request until ack or aborts.
        hr_act = 1'b0; hr_we = 1'b0; hr_addr = 12'h000; hr_wd = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            if (!hr_act && $urandom_range(0, 2) == 0) begin
                hr_act  = 1'b1;
                hr_we   = $urandom_range(0, 1) == 1;
                hr_addr = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(12'h0F8, 12'h107))
                                                     : 12'($urandom_range(0, 4095));
                hr_wd   = 16'($urandom);
            end else if (hr_act && $urandom_range(0, 15) == 0) begin
                hr_act = 1'b0;
            end
            drive($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
                  12'($urandom_range(0, 4095)), hr_act, hr_we, hr_addr, hr_wd);
            if (host_ack) hr_act = 1'b0;
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
